regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the Minisys-1A pipelined core, replacing the single-cycle decode-stage register array. It provides NREAD combinational read ports, one write-back port with optional same-cycle bypass, and a per-register pending-write scoreboard. Decode uses the scoreboard to detect read-after-write hazards and stalls; write-back retires writes in order.

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with NREAD combinational read ports, one write-back port
// with optional same-cycle bypass, and per-register pending-write counters for hazard detection.
module regfile_scoreboard #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NREAD       = 2,
    parameter int CNT_W       = 2,
    parameter int BYPASS      = 1,
    parameter int RESET_INDEX = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    issue_valid,
    input  logic [ADDR_W-1:0]       issue_addr,
    output logic                    issue_ready,
    input  logic                    wb_valid,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic                    flush,
    output logic                    busy_any,
    output logic                    err_wb_idle
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  cnt  [DEPTH];
    logic              accept;
    logic              err_next;

    assign issue_ready = (issue_addr == '0) || (cnt[issue_addr] != CNT_MAX);
    assign accept      = issue_valid && issue_ready;
    assign err_next    = wb_valid && (wb_addr != '0) && (cnt[wb_addr] == '0) && !flush;

    // NOTE: the array has architectural reset values, so it is reset explicitly; a plain
    // storage RAM would normally be left unreset so it can map onto memory macros.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (RESET_INDEX != 0) ? DATA_W'(i) : '0;
        end else if (wb_valid && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Register 0 can never be claimed, so its counter is pinned at zero.
    always_ff @(posedge clock) begin
        cnt[0] <= '0;
        for (int r = 1; r < DEPTH; r++) begin
            if (reset || flush) begin
                cnt[r] <= '0;
            end else begin
                if (accept && (issue_addr == ADDR_W'(r)) &&
                    !(wb_valid && (wb_addr == ADDR_W'(r)) && (cnt[r] != '0)))
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (!(accept && (issue_addr == ADDR_W'(r))) &&
                         wb_valid && (wb_addr == ADDR_W'(r)) && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) err_wb_idle <= 1'b0;
        else       err_wb_idle <= err_next;
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              fwd;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NREAD; k++) begin
            a   = rd_addr[k*ADDR_W +: ADDR_W];
            fwd = (BYPASS != 0) && wb_valid && (wb_addr == a);
            if (a == '0)
                rd_data[k*DATA_W +: DATA_W] = '0;
            else if (fwd)
                rd_data[k*DATA_W +: DATA_W] = wb_data;
            else
                rd_data[k*DATA_W +: DATA_W] = regs[a];
            // The final outstanding write being forwarded this cycle clears the hazard.
            rd_busy[k] = (cnt[a] != '0) && !(fwd && (cnt[a] == CNT_W'(1)));
        end
    end

    always_comb begin
        busy_any = 1'b0;
        for (int r = 0; r < DEPTH; r++)
            busy_any = busy_any | (cnt[r] != '0);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expected values are queued when stimulus is driven
// and popped against DUT outputs on the falling edge.
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data, rd_data_nb;
    logic [NREAD-1:0]        rd_busy, rd_busy_nb;
    logic                    issue_valid;
    logic [ADDR_W-1:0]       issue_addr;
    logic                    issue_ready, issue_ready_nb;
    logic                    wb_valid;
    logic [ADDR_W-1:0]       wb_addr;
    logic [DATA_W-1:0]       wb_data;
    logic                    flush;
    logic                    busy_any, busy_any_nb;
    logic                    err_wb_idle, err_wb_idle_nb;

    always #5 clock = ~clock;

    regfile_scoreboard #(.BYPASS(1)) dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .busy_any(busy_any), .err_wb_idle(err_wb_idle)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready_nb),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .busy_any(busy_any_nb), .err_wb_idle(err_wb_idle_nb)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expect_val(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h required none", obs);
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] p1, input logic [ADDR_W-1:0] p0);
        rd_addr = {p1, p0};
    endtask

    initial begin
        reset = 1'b1; rd_addr = '0; issue_valid = 1'b0; issue_addr = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
        next_cycle();
        next_cycle();

        // Reset contents with RESET_INDEX=1
        reset = 1'b0; set_rd(5'd5, 5'd3); issue_addr = 5'd7;
        expect_val("reset_rd_data", 64'h0000_0005_0000_0003);
        expect_val("reset_busy_any", 64'd0);
        expect_val("reset_issue_ready", 64'd1);
        expect_val("reset_rd_busy", 64'd0);
        expect_val("reset_err", 64'd0);
        settle();
        check(rd_data); check(busy_any); check(issue_ready); check(rd_busy); check(err_wb_idle);

        // Claim r7, write it back three cycles later
        next_cycle(); issue_valid = 1'b1; issue_addr = 5'd7; set_rd(5'd0, 5'd7);
        expect_val("claim7_busy_same_cycle", 64'd0);
        settle(); check(rd_busy[0]);
        next_cycle(); issue_valid = 1'b0;
        expect_val("r7_busy_wait1", 64'd1);
        expect_val("r7_busy_any", 64'd1);
        settle(); check(rd_busy[0]); check(busy_any);
        next_cycle();
        expect_val("r7_busy_wait2", 64'd1);
        settle(); check(rd_busy[0]);
        next_cycle(); wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
        expect_val("r7_bypass_data", 64'hDEAD_BEEF);
        expect_val("r7_bypass_busy", 64'd0);
        expect_val("r7_nobypass_data", 64'd7);
        expect_val("r7_nobypass_busy", 64'd1);
        settle(); check(rd_data[31:0]); check(rd_busy[0]); check(rd_data_nb[31:0]); check(rd_busy_nb[0]);
        next_cycle(); wb_valid = 1'b0;
        expect_val("r7_stored_data", 64'hDEAD_BEEF);
        expect_val("r7_busy_any_clear", 64'd0);
        expect_val("r7_err", 64'd0);
        settle(); check(rd_data[31:0]); check(busy_any); check(err_wb_idle);

        // Saturate r4's counter; a fourth claim must be refused
        set_rd(5'd4, 5'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); issue_valid = 1'b1; issue_addr = 5'd4;
            expect_val($sformatf("r4_ready_claim%0d", i), 64'd1);
            settle(); check(issue_ready);
        end
        next_cycle();
        expect_val("r4_ready_full", 64'd0);
        expect_val("r4_busy_full", 64'd1);
        settle(); check(issue_ready); check(rd_busy[1]);
        next_cycle(); issue_valid = 1'b0; issue_addr = 5'd5;
        expect_val("r5_ready", 64'd1);
        settle(); check(issue_ready);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'(i + 1);
            expect_val($sformatf("r4_busy_wb%0d", i), (i == 2) ? 64'd0 : 64'd1);
            settle(); check(rd_busy[1]);
        end
        next_cycle(); wb_valid = 1'b0;
        expect_val("r4_busy_any_clear", 64'd0);
        expect_val("r4_stored_data", 64'd3);
        expect_val("r4_err", 64'd0);
        settle(); check(busy_any); check(rd_data[63:32]); check(err_wb_idle);

        // Simultaneous claim and write-back on r9, then write to r0
        next_cycle(); issue_valid = 1'b1; issue_addr = 5'd9; set_rd(5'd0, 5'd9);
        settle();
        next_cycle(); wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        expect_val("r9_same_cycle_busy", 64'd0);
        expect_val("r9_same_cycle_data", 64'h99);
        settle(); check(rd_busy[0]); check(rd_data[31:0]);
        next_cycle(); issue_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        expect_val("r9_still_busy", 64'd1);
        expect_val("r0_read_during_wb", 64'd0);
        expect_val("r9_err", 64'd0);
        settle(); check(rd_busy[0]); check(rd_data[63:32]); check(err_wb_idle);
        next_cycle(); wb_addr = 5'd9; wb_data = 32'h9A;
        expect_val("r0_err", 64'd0);
        expect_val("r0_read_after_wb", 64'd0);
        settle(); check(err_wb_idle); check(rd_data[63:32]);
        next_cycle(); wb_valid = 1'b0;
        expect_val("r9_busy_any_clear", 64'd0);
        settle(); check(busy_any);

        // Flush with pending claims on r2/r3
        next_cycle(); issue_valid = 1'b1; issue_addr = 5'd2; settle();
        next_cycle(); issue_addr = 5'd3; settle();
        next_cycle(); issue_valid = 1'b0; flush = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h11; set_rd(5'd3, 5'd2);
        expect_val("flush_busy_any_before", 64'd1);
        settle(); check(busy_any);
        next_cycle(); flush = 1'b0; wb_valid = 1'b0;
        expect_val("flush_busy_any_after", 64'd0);
        expect_val("flush_r2_data", 64'h11);
        expect_val("flush_err", 64'd0);
        expect_val("flush_rd_busy", 64'd0);
        settle(); check(busy_any); check(rd_data[31:0]); check(err_wb_idle); check(rd_busy);
        next_cycle(); wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        expect_val("r3_idle_wb_err_same", 64'd0);
        settle(); check(err_wb_idle);
        next_cycle(); wb_valid = 1'b0;
        expect_val("r3_idle_wb_err_pulse", 64'd1);
        expect_val("r3_data", 64'h33);
        settle(); check(err_wb_idle); check(rd_data[63:32]);
        next_cycle(); flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h88;
        expect_val("r3_err_pulse_end", 64'd0);
        settle(); check(err_wb_idle);
        next_cycle(); flush = 1'b0; wb_valid = 1'b0;
        expect_val("flush_suppresses_err", 64'd0);
        settle(); check(err_wb_idle);

        // BYPASS=0 instance returns the old value during the write-back cycle
        next_cycle(); wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h55; set_rd(5'd0, 5'd6);
        expect_val("r6_nobypass_old", 64'd6);
        expect_val("r6_bypass_new", 64'h55);
        settle(); check(rd_data_nb[31:0]); check(rd_data[31:0]);
        next_cycle(); wb_valid = 1'b0;
        expect_val("r6_nobypass_stored", 64'h55);
        expect_val("r6_nobypass_err", 64'd1);
        settle(); check(rd_data_nb[31:0]); check(err_wb_idle_nb);

        // Reset mid-operation discards the claim and the same-cycle write-back
        next_cycle(); issue_valid = 1'b1; issue_addr = 5'd10; set_rd(5'd7, 5'd10); settle();
        next_cycle(); issue_valid = 1'b0; reset = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hAB; settle();
        next_cycle(); reset = 1'b0; wb_valid = 1'b0;
        expect_val("midreset_rd_data", 64'h0000_0007_0000_000A);
        expect_val("midreset_busy_any", 64'd0);
        expect_val("midreset_err", 64'd0);
        expect_val("midreset_issue_ready", 64'd1);
        expect_val("midreset_nb_busy_any", 64'd0);
        expect_val("midreset_nb_ready", 64'd1);
        expect_val("midreset_nb_busy", 64'd0);
        settle();
        check(rd_data); check(busy_any); check(err_wb_idle); check(issue_ready);
        check(busy_any_nb); check(issue_ready_nb); check(rd_busy_nb);

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
